// File: rtl/gate_pipe_if.sv
// Handshake bundle for gate_pipe: operand/op input channel, result output channel, busy flag.
interface gate_pipe_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
);
    logic                    in_valid;
    logic                    in_ready;
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [1:0]              op;
    logic                    out_valid;
    logic                    out_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    busy;

    modport master (
        output in_valid, in_data, op, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, op, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/gate_pipe.sv
// Bitwise AND/OR/XOR/NAND reduction over NUM_IN operands, DEPTH-stage elastic pipeline.
// Optional GATE_PIPE_CNT_EN adds a 16-bit wrapping output-transfer counter (xfer_cnt).
module gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int DEPTH  = 2
) (
    input  logic          clk,
    input  logic          reset,
    gate_pipe_if.slave    bus
`ifdef GATE_PIPE_CNT_EN
    ,
    output logic [15:0]   xfer_cnt
`endif
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [DEPTH-1:0] load_en;
    logic [WIDTH-1:0] red;
    logic             chain;

    // The op is folded into the result at capture, so later op changes cannot touch it.
    always_comb begin
        red = bus.in_data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            case (bus.op)
                2'b01:   red = red | bus.in_data[k*WIDTH +: WIDTH];
                2'b10:   red = red ^ bus.in_data[k*WIDTH +: WIDTH];
                default: red = red & bus.in_data[k*WIDTH +: WIDTH];
            endcase
        end
        if (bus.op == 2'b11) begin
            red = ~red;
        end
    end

    // A stage may load when it is empty or its occupant moves on; this collapses bubbles.
    always_comb begin
        load_en          = '0;
        chain            = !vld_q[DEPTH-1] || bus.out_ready;
        load_en[DEPTH-1] = chain;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            chain      = !vld_q[k] || chain;
            load_en[k] = chain;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat_q[k] <= '0;
            end
        end else begin
            if (load_en[0]) begin
                vld_q[0] <= bus.in_valid;
                if (bus.in_valid) begin
                    dat_q[0] <= red;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (load_en[k]) begin
                    vld_q[k] <= vld_q[k-1];
                    if (vld_q[k-1]) begin
                        dat_q[k] <= dat_q[k-1];
                    end
                end
            end
        end
    end

    assign bus.in_ready  = load_en[0];
    assign bus.out_valid = vld_q[DEPTH-1];
    assign bus.out_data  = dat_q[DEPTH-1];
    assign bus.busy      = |vld_q;

`ifdef GATE_PIPE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_cnt <= '0;
        end else if (vld_q[DEPTH-1] && bus.out_ready) begin
            xfer_cnt <= xfer_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gate_pipe.sv
// Bench for gate_pipe: a default instance and a NUM_IN=3/DEPTH=4 instance against a queue model.
module tb_gate_pipe;
    localparam int W  = 8;
    localparam int NA = 2;
    localparam int DA = 2;
    localparam int NB = 3;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    gate_pipe_if #(.WIDTH(W), .NUM_IN(NA)) ifa ();
    gate_pipe_if #(.WIDTH(W), .NUM_IN(NB)) ifb ();

`ifdef GATE_PIPE_CNT_EN
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;
`endif

    gate_pipe #(.WIDTH(W), .NUM_IN(NA), .DEPTH(DA)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa)
`ifdef GATE_PIPE_CNT_EN
        , .xfer_cnt(cnt_a)
`endif
    );

    gate_pipe #(.WIDTH(W), .NUM_IN(NB), .DEPTH(DB)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb)
`ifdef GATE_PIPE_CNT_EN
        , .xfer_cnt(cnt_b)
`endif
    );

    // model: per instance, a FIFO of expected results with the edge number each was accepted on
    logic [7:0] mres [2][16];
    int         macc [2][16];
    int         head [2];
    int         cnt  [2];
    int         n_out [2];
    int         n_acc [2];
    logic [7:0] last_obs [2];
    logic [7:0] dlv [2][64];
    int         cyc;
    int         n_chk;
    int         n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] red_model(input int n, input logic [63:0] data, input logic [1:0] op);
        logic [7:0] r;
        logic [7:0] v;
        r = (op == 2'b01 || op == 2'b10) ? 8'h00 : 8'hFF;
        for (int i = 0; i < n; i++) begin
            v = data[i*8 +: 8];
            case (op)
                2'b01:   r = r | v;
                2'b10:   r = r ^ v;
                default: r = r & v;
            endcase
        end
        if (op == 2'b11) r = ~r;
        return r;
    endfunction

    task automatic model_clear();
        for (int d = 0; d < 2; d++) begin
            head[d]  = 0;
            cnt[d]   = 0;
            n_out[d] = 0;
        end
    endtask

    // The oldest entry has nothing ahead of it, so it reaches the output DEPTH-1 edges after acceptance.
    task automatic check_dut(input int d, input logic ir, input logic ov, input logic [7:0] od,
                             input logic bz, input logic ordy, output bit ir_e, output bit ov_e);
        int    dep;
        string nm;
        dep  = (d == 0) ? DA : DB;
        nm   = (d == 0) ? "a" : "b";
        ir_e = (cnt[d] < dep) || ordy;
        ov_e = (cnt[d] > 0) && ((cyc - macc[d][head[d]]) >= dep - 1);
        chk({nm, "_in_ready"}, 64'(ir), 64'(ir_e));
        chk({nm, "_out_valid"}, 64'(ov), 64'(ov_e));
        chk({nm, "_busy"}, 64'(bz), 64'(cnt[d] > 0));
        if (ov_e) begin
            chk({nm, "_out_data"}, 64'(od), 64'(mres[d][head[d]]));
            last_obs[d] = od;
        end
`ifdef GATE_PIPE_CNT_EN
        chk({nm, "_xfer_cnt"}, 64'((d == 0) ? cnt_a : cnt_b), 64'(n_out[d] & 16'hFFFF));
`endif
    endtask

    task automatic commit(input int d, input bit in_f, input logic [7:0] res, input bit out_f);
        int tail;
        if (out_f) begin
            dlv[d][n_out[d] % 64] = last_obs[d];
            head[d] = (head[d] + 1) % 16;
            cnt[d]--;
            n_out[d]++;
        end
        if (in_f) begin
            tail = (head[d] + cnt[d]) % 16;
            mres[d][tail] = res;
            macc[d][tail] = cyc;
            cnt[d]++;
            n_acc[d]++;
        end
    endtask

    // One clock cycle: drive at the falling edge, check 1ns later, update the model at the rising edge.
    task automatic step(input bit va, input logic [63:0] da, input logic [1:0] oa, input bit ra,
                        input bit vb, input logic [63:0] db, input logic [1:0] ob, input bit rb);
        bit ir_a, ov_a, ir_b, ov_b;
        ifa.in_valid  = va;
        ifa.in_data   = da[NA*W-1:0];
        ifa.op        = oa;
        ifa.out_ready = ra;
        ifb.in_valid  = vb;
        ifb.in_data   = db[NB*W-1:0];
        ifb.op        = ob;
        ifb.out_ready = rb;
        #1;
        check_dut(0, ifa.in_ready, ifa.out_valid, ifa.out_data, ifa.busy, ra, ir_a, ov_a);
        check_dut(1, ifb.in_ready, ifb.out_valid, ifb.out_data, ifb.busy, rb, ir_b, ov_b);
        @(posedge clk);
        cyc++;
        commit(0, va && ir_a, red_model(NA, da, oa), ov_a && ra);
        commit(1, vb && ir_b, red_model(NB, db, ob), ov_b && rb);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 64'h0, 2'b00, 1, 0, 64'h0, 2'b00, 1);
    endtask

    initial begin
        int base, base_acc;
        logic [63:0] rnd;
        n_chk  = 0;
        n_fail = 0;
        cyc    = 0;
        for (int d = 0; d < 2; d++) n_acc[d] = 0;
        model_clear();
        reset = 1'b1;
        ifa.in_valid = 0; ifa.in_data = '0; ifa.op = 2'b00; ifa.out_ready = 0;
        ifb.in_valid = 0; ifb.in_data = '0; ifb.op = 2'b00; ifb.out_ready = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(ifa.in_ready), 64'd1);
        chk("rst_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("rst_out_data", 64'(ifa.out_data), 64'd0);
        chk("rst_busy", 64'(ifb.busy), 64'd0);
        reset = 1'b0;

        // single AND transfer on the default instance
        base = n_out[0];
        step(1, 64'hF03C, 2'b00, 1, 0, 64'h0, 2'b00, 1);
        idle(4);
        chk("r030_count", 64'(n_out[0] - base), 64'd1);
        chk("r030_data", 64'(dlv[0][base % 64]), 64'h30);

        // XOR then NAND over three operands, in order
        base = n_out[1];
        step(0, 64'h0, 2'b00, 1, 1, 64'hFF0FAA, 2'b10, 1);
        step(0, 64'h0, 2'b00, 1, 1, 64'h0FFFFF, 2'b11, 1);
        idle(6);
        chk("r031_count", 64'(n_out[1] - base), 64'd2);
        chk("r031_first", 64'(dlv[1][base % 64]), 64'h5A);
        chk("r031_second", 64'(dlv[1][(base + 1) % 64]), 64'hF0);

        // fill DEPTH=4 with the sink stalled, then drain; ops change while stalled
        base_acc = n_acc[1];
        for (int i = 0; i < 7; i++) begin
            rnd = {$urandom(), $urandom()};
            step(0, 64'h0, 2'b00, 1, 1, rnd, 2'($urandom_range(0, 3)), 0);
        end
        chk("r032_accepted", 64'(n_acc[1] - base_acc), 64'd4);
        base = n_out[1];
        for (int i = 0; i < 4; i++) step(0, 64'h0, 2'b00, 1, 0, 64'h0, 2'b00, 1);
        chk("r032_drained", 64'(n_out[1] - base), 64'd4);
        chk("r032_busy", 64'(ifb.busy), 64'd0);

        // full pipe streaming
        for (int i = 0; i < 3; i++) step(1, {$urandom(), $urandom()}, 2'($urandom_range(0, 3)), 0, 0, 64'h0, 2'b00, 1);
        base_acc = n_acc[0];
        base     = n_out[0];
        for (int i = 0; i < 20; i++) step(1, {$urandom(), $urandom()}, 2'($urandom_range(0, 3)), 1, 0, 64'h0, 2'b00, 1);
        chk("r033_accepted", 64'(n_acc[0] - base_acc), 64'd20);
        chk("r033_delivered", 64'(n_out[0] - base), 64'd20);
        idle(6);

        // asynchronous reset with entries in flight
        for (int i = 0; i < 2; i++) step(1, {$urandom(), $urandom()}, 2'b01, 0, 1, {$urandom(), $urandom()}, 2'b10, 0);
        ifa.in_valid = 0; ifb.in_valid = 0;
        #2;
        reset = 1'b1;
        #1;
        chk("r034_a_out_valid", 64'(ifa.out_valid), 64'd0);
        chk("r034_a_busy", 64'(ifa.busy), 64'd0);
        chk("r034_a_out_data", 64'(ifa.out_data), 64'd0);
        chk("r034_a_in_ready", 64'(ifa.in_ready), 64'd1);
        chk("r034_b_busy", 64'(ifb.busy), 64'd0);
        chk("r034_b_out_data", 64'(ifb.out_data), 64'd0);
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        idle(5);
        step(1, 64'hF03C, 2'b00, 1, 0, 64'h0, 2'b00, 1);
        idle(3);
        chk("r034_post_count", 64'(n_out[0]), 64'd1);

        // random traffic on both instances
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom(), $urandom()}, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, {$urandom(), $urandom()}, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 2) != 0);
        end
        idle(8);
        chk("end_a_empty", 64'(cnt[0]), 64'd0);
        chk("end_b_busy", 64'(ifb.busy), 64'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
